// File: rtl/fm_ycbcr_pkg.sv
// Shared types, coefficient table and helpers for the RGB -> YCbCr converter.
// Coefficients are signed with COEF_FRAC fractional bits, ordered [mode][channel][R,G,B].
package fm_ycbcr_pkg;

  typedef enum logic [1:0] {
    MODE_601_LIM  = 2'd0,
    MODE_709_LIM  = 2'd1,
    MODE_601_FULL = 2'd2,
    MODE_BYPASS   = 2'd3
  } mode_e;

  localparam int COEF_FRAC   = 12;
  localparam int COEF_W      = 13;
  localparam int CSC_LATENCY = 3;

  localparam int CH_Y  = 0;
  localparam int CH_CB = 1;
  localparam int CH_CR = 2;

  localparam int COEF_TABLE [3][3][3] = '{
    '{'{1052, 2064, 401}, '{-606, -1192, 1798}, '{1798, -1507, -291}},
    '{'{ 750, 2515, 254}, '{-414, -1384, 1798}, '{1798, -1634, -164}},
    '{'{1225, 2404, 467}, '{-691, -1357, 2048}, '{2048, -1715, -333}}
  };

  // Bypass has no matrix; it returns zero so the multipliers stay quiet.
  function automatic logic signed [COEF_W-1:0] coef(input mode_e mode,
                                                    input logic [1:0] ch,
                                                    input logic [1:0] comp);
    if (mode == MODE_BYPASS) return '0;
    return COEF_W'(COEF_TABLE[mode][ch][comp]);
  endfunction

  function automatic int ch_offset(input mode_e mode, input logic [1:0] ch, input int dw);
    if (mode == MODE_BYPASS) return 0;
    if (ch == 2'(CH_Y)) return (mode == MODE_601_FULL) ? 0 : (16 << (dw - 8));
    return 128 << (dw - 8);
  endfunction

endpackage

// File: rtl/fm_ycbcr_mac.sv
// One output channel: multiply (stage 1), 3-term sum (stage 2), round/offset/clamp (stage 3).
// The mode travels with the pixel so a mode change never splits a pixel across two matrices.
module fm_ycbcr_mac
  import fm_ycbcr_pkg::*;
#(
  parameter int P_DW = 8,
  parameter int P_CH = CH_Y
) (
  input  logic            clk_v,
  input  logic            rst_x,
  input  logic [1:0]      i_mode,
  input  logic [P_DW-1:0] i_r,
  input  logic [P_DW-1:0] i_g,
  input  logic [P_DW-1:0] i_b,
  input  logic [P_DW-1:0] i_pass,
  output logic [P_DW-1:0] o_d
);

  localparam int         PW         = P_DW + COEF_W + 1;
  localparam int         SW         = PW + 2;
  localparam int         ROUND_HALF = 1 << (COEF_FRAC - 1);
  localparam int         PIX_MAX    = (1 << P_DW) - 1;
  localparam logic [1:0] CH         = 2'(P_CH);

  mode_e                 md;
  logic signed [PW-1:0]  r_s, g_s, b_s;
  logic signed [PW-1:0]  prod_r, prod_g, prod_b;
  logic signed [PW-1:0]  prod_r_q, prod_g_q, prod_b_q;
  logic signed [SW-1:0]  sum_q;
  logic signed [SW-1:0]  rnd, ofs;
  logic [P_DW-1:0]       pass1_q, pass2_q;
  mode_e                 mode1_q, mode2_q;
  logic [P_DW-1:0]       d_n;

  always_comb begin
    md     = mode_e'(i_mode);
    r_s    = PW'($signed({1'b0, i_r}));
    g_s    = PW'($signed({1'b0, i_g}));
    b_s    = PW'($signed({1'b0, i_b}));
    prod_r = r_s * PW'(coef(md, CH, 2'd0));
    prod_g = g_s * PW'(coef(md, CH, 2'd1));
    prod_b = b_s * PW'(coef(md, CH, 2'd2));
  end

  // Round half up via floor(x + 0.5), then offset and saturate to the pixel range.
  always_comb begin
    rnd = (sum_q + SW'(ROUND_HALF)) >>> COEF_FRAC;
    ofs = rnd + SW'(ch_offset(mode2_q, CH, P_DW));
    if (mode2_q == MODE_BYPASS)     d_n = pass2_q;
    else if (ofs[SW-1])             d_n = '0;
    else if (ofs > SW'(PIX_MAX))    d_n = P_DW'(PIX_MAX);
    else                            d_n = ofs[P_DW-1:0];
  end

  always_ff @(posedge clk_v or negedge rst_x) begin
    if (!rst_x) begin
      prod_r_q <= '0;
      prod_g_q <= '0;
      prod_b_q <= '0;
      pass1_q  <= '0;
      mode1_q  <= MODE_601_LIM;
      sum_q    <= '0;
      pass2_q  <= '0;
      mode2_q  <= MODE_601_LIM;
      o_d      <= '0;
    end else begin
      prod_r_q <= prod_r;
      prod_g_q <= prod_g;
      prod_b_q <= prod_b;
      pass1_q  <= i_pass;
      mode1_q  <= md;
      sum_q    <= SW'(prod_r_q) + SW'(prod_g_q) + SW'(prod_b_q);
      pass2_q  <= pass1_q;
      mode2_q  <= mode1_q;
      o_d      <= d_n;
    end
  end

endmodule

// File: rtl/fm_ycbcr_csc.sv
// RGB -> YCbCr converter, 3-stage free-running pipeline with frame-synchronous mode shadow.
// Define FM_YCBCR_422_EN for 4:2:2 output (Cb/Cr multiplexed onto o_cb, o_cr held at 0).
module fm_ycbcr_csc
  import fm_ycbcr_pkg::*;
#(
  parameter int P_DW = 8
) (
  input  logic            clk_v,
  input  logic            rst_x,
  input  logic [1:0]      i_mode,
  input  logic            i_valid,
  input  logic            i_hsync,
  input  logic            i_vsync,
  input  logic [P_DW-1:0] i_r,
  input  logic [P_DW-1:0] i_g,
  input  logic [P_DW-1:0] i_b,
  output logic            o_valid,
  output logic            o_hsync,
  output logic            o_vsync,
  output logic [P_DW-1:0] o_y,
  output logic [P_DW-1:0] o_cb,
  output logic [P_DW-1:0] o_cr
);

  mode_e                  mode_q;
  logic                   vsync_prev_q;
  logic [CSC_LATENCY-1:0] valid_sr, hsync_sr, vsync_sr;
  logic [P_DW-1:0]        y_d, cb_d, cr_d;

  // Mode is only picked up on a vsync rising edge so a frame never mixes matrices.
  always_ff @(posedge clk_v or negedge rst_x) begin
    if (!rst_x) begin
      mode_q       <= MODE_601_LIM;
      vsync_prev_q <= 1'b0;
      valid_sr     <= '0;
      hsync_sr     <= '0;
      vsync_sr     <= '0;
    end else begin
      if (i_vsync && !vsync_prev_q) mode_q <= mode_e'(i_mode);
      vsync_prev_q <= i_vsync;
      valid_sr     <= {valid_sr[CSC_LATENCY-2:0], i_valid};
      hsync_sr     <= {hsync_sr[CSC_LATENCY-2:0], i_hsync};
      vsync_sr     <= {vsync_sr[CSC_LATENCY-2:0], i_vsync};
    end
  end

  assign o_valid = valid_sr[CSC_LATENCY-1];
  assign o_hsync = hsync_sr[CSC_LATENCY-1];
  assign o_vsync = vsync_sr[CSC_LATENCY-1];
  assign o_y     = y_d;

  fm_ycbcr_mac #(.P_DW(P_DW), .P_CH(CH_Y)) u_mac_y (
    .clk_v(clk_v), .rst_x(rst_x), .i_mode(mode_q),
    .i_r(i_r), .i_g(i_g), .i_b(i_b), .i_pass(i_g), .o_d(y_d)
  );

  fm_ycbcr_mac #(.P_DW(P_DW), .P_CH(CH_CB)) u_mac_cb (
    .clk_v(clk_v), .rst_x(rst_x), .i_mode(mode_q),
    .i_r(i_r), .i_g(i_g), .i_b(i_b), .i_pass(i_b), .o_d(cb_d)
  );

  fm_ycbcr_mac #(.P_DW(P_DW), .P_CH(CH_CR)) u_mac_cr (
    .clk_v(clk_v), .rst_x(rst_x), .i_mode(mode_q),
    .i_r(i_r), .i_g(i_g), .i_b(i_b), .i_pass(i_r), .o_d(cr_d)
  );

`ifdef FM_YCBCR_422_EN
  logic            phase_q;
  logic [P_DW-1:0] cr_hold_q;

  // Phase-1 pixels carry the Cr of the preceding phase-0 pixel (co-sited chroma).
  always_ff @(posedge clk_v or negedge rst_x) begin
    if (!rst_x) begin
      phase_q   <= 1'b0;
      cr_hold_q <= '0;
    end else begin
      if (o_hsync)      phase_q <= 1'b0;
      else if (o_valid) phase_q <= ~phase_q;
      if (o_valid && !phase_q) cr_hold_q <= cr_d;
    end
  end

  assign o_cb = phase_q ? cr_hold_q : cb_d;
  assign o_cr = '0;
`else
  assign o_cb = cb_d;
  assign o_cr = cr_d;
`endif

endmodule

// File: tb/tb_fm_ycbcr_csc.sv
// Directed bench for fm_ycbcr_csc at P_DW=8 with hand-computed expected pixels.
module tb_fm_ycbcr_csc;

  localparam int DW = 8;

  logic          clk_v = 1'b0;
  logic          rst_x = 1'b1;
  logic [1:0]    i_mode = 2'd0;
  logic          i_valid = 1'b0, i_hsync = 1'b0, i_vsync = 1'b0;
  logic [DW-1:0] i_r = '0, i_g = '0, i_b = '0;
  logic          o_valid, o_hsync, o_vsync;
  logic [DW-1:0] o_y, o_cb, o_cr;

  int n_cmp = 0;
  int n_err = 0;
  logic [3*DW:0] exp_q[$];

  fm_ycbcr_csc #(.P_DW(DW)) dut (
    .clk_v(clk_v), .rst_x(rst_x), .i_mode(i_mode),
    .i_valid(i_valid), .i_hsync(i_hsync), .i_vsync(i_vsync),
    .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .o_valid(o_valid), .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_y(o_y), .o_cb(o_cb), .o_cr(o_cr)
  );

  // Clock / reset
  always #5 clk_v = ~clk_v;

  // Driver tasks
  task automatic tick();
    @(posedge clk_v);
    #1;
  endtask

  task automatic drive(input logic v, input logic hs, input logic vs,
                       input logic [DW-1:0] r, input logic [DW-1:0] g, input logic [DW-1:0] b);
    i_valid = v; i_hsync = hs; i_vsync = vs;
    i_r = r; i_g = g; i_b = b;
  endtask

  task automatic set_mode(input logic [1:0] m);
    i_mode = m;
    drive(1'b0, 1'b0, 1'b1, '0, '0, '0);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick();
  endtask

  // Scenarios
  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 8'd200, 8'd100, 8'd50);
    #1 rst_x = 1'b0;
    #1;
    n_cmp++;
    if ({o_valid, o_hsync, o_vsync, o_y, o_cb, o_cr} !== 27'd0) begin
      n_err++;
      $display("FAIL reset_async: got v=%b h=%b vs=%b y=%0d cb=%0d cr=%0d want all 0",
               o_valid, o_hsync, o_vsync, o_y, o_cb, o_cr);
    end
    tick(); tick();
    n_cmp++;
    if ({o_valid, o_hsync, o_vsync, o_y, o_cb, o_cr} !== 27'd0) begin
      n_err++;
      $display("FAIL reset_held: got v=%b y=%0d cb=%0d cr=%0d want all 0", o_valid, o_y, o_cb, o_cr);
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    rst_x = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_mode_switch();
    set_mode(2'd0);
    i_mode = 2'd1;
    drive(1'b1, 1'b0, 1'b0, 8'd255, 8'd0, 8'd0);
    for (int k = 0; k < 5; k++) tick();
    n_cmp++;
    if (o_y !== 8'd81) begin
      n_err++;
      $display("FAIL mode_hold_y: got %0d want 81", o_y);
    end
    i_vsync = 1'b1;
    tick();
    i_vsync = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({o_vsync, o_y} !== {1'b1, 8'd81}) begin
      n_err++;
      $display("FAIL mode_capture_pixel: got vs=%b y=%0d want vs=1 y=81", o_vsync, o_y);
    end
    tick();
    n_cmp++;
    if ({o_vsync, o_y} !== {1'b0, 8'd63}) begin
      n_err++;
      $display("FAIL mode_709_y: got vs=%b y=%0d want vs=0 y=63", o_vsync, o_y);
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick(); tick(); tick();
  endtask

  task automatic test_flags();
    logic [2:0] pat [6] = '{3'b010, 3'b001, 3'b100, 3'b111, 3'b000, 3'b011};
    logic [2:0] want;
    for (int k = 0; k < 8; k++) begin
      if (k < 6) begin
        drive(pat[k][2], pat[k][1], pat[k][0], 8'(k * 17), 8'(k * 5), 8'(k * 3));
        exp_q.push_back({{(3*DW-2){1'b0}}, pat[k]});
      end else begin
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      end
      tick();
      if (k >= 2) begin
        want = exp_q.pop_front()[2:0];
        n_cmp++;
        if ({o_valid, o_hsync, o_vsync} !== want) begin
          n_err++;
          $display("FAIL flags_%0d: got %b want %b", k - 2, {o_valid, o_hsync, o_vsync}, want);
        end
      end
    end
    tick();
  endtask

  task automatic test_reset_midstream();
    set_mode(2'd3);
    drive(1'b1, 1'b0, 1'b0, 8'd255, 8'd0, 8'd0);
    for (int k = 0; k < 10; k++) tick();
    n_cmp++;
    if ({o_valid, o_y, o_cr} !== {1'b1, 8'd0, 8'd255}) begin
      n_err++;
      $display("FAIL pre_reset_bypass: got v=%b y=%0d cr=%0d want v=1 y=0 cr=255", o_valid, o_y, o_cr);
    end
    rst_x = 1'b0;
    #1;
    n_cmp++;
    if ({o_valid, o_hsync, o_vsync, o_y, o_cb, o_cr} !== 27'd0) begin
      n_err++;
      $display("FAIL midstream_reset: got v=%b y=%0d cb=%0d cr=%0d want all 0", o_valid, o_y, o_cb, o_cr);
    end
    tick();
    rst_x = 1'b1;
    tick(); tick();
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_early_valid: got %b want 0", o_valid);
    end
    tick();
    n_cmp++;
    if ({o_valid, o_y} !== {1'b1, 8'd81}) begin
      n_err++;
      $display("FAIL post_reset_first: got v=%b y=%0d want v=1 y=81", o_valid, o_y);
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick(); tick(); tick();
  endtask

`ifndef FM_YCBCR_422_EN
  task automatic test_latency();
    set_mode(2'd0);
    drive(1'b1, 1'b0, 1'b0, 8'd255, 8'd255, 8'd255);
    tick();
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    tick();
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL latency_early: got v=%b want 0", o_valid);
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    n_cmp++;
    if ({o_valid, o_y, o_cb, o_cr} !== {1'b1, 8'd235, 8'd128, 8'd128}) begin
      n_err++;
      $display("FAIL white_601: got v=%b %0d/%0d/%0d want 1 235/128/128", o_valid, o_y, o_cb, o_cr);
    end
    tick();
    n_cmp++;
    if ({o_valid, o_y, o_cb, o_cr} !== {1'b1, 8'd16, 8'd128, 8'd128}) begin
      n_err++;
      $display("FAIL black_601: got v=%b %0d/%0d/%0d want 1 16/128/128", o_valid, o_y, o_cb, o_cr);
    end
    tick();
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL latency_tail: got v=%b want 0", o_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [3*DW-1:0] rgb [5] = '{24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h000000};
    logic [3*DW-1:0] ycc [5] = '{{8'd235, 8'd128, 8'd128}, {8'd81, 8'd90, 8'd240},
                                 {8'd144, 8'd54, 8'd34}, {8'd41, 8'd240, 8'd110},
                                 {8'd16, 8'd128, 8'd128}};
    logic [3*DW:0] want;
    for (int k = 0; k < 7; k++) begin
      if (k < 5) begin
        drive(1'b1, 1'b0, 1'b0, rgb[k][23:16], rgb[k][15:8], rgb[k][7:0]);
        exp_q.push_back({1'b1, ycc[k]});
      end else begin
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      end
      tick();
      if (k >= 2) begin
        want = exp_q.pop_front();
        n_cmp++;
        if ({o_valid, o_y, o_cb, o_cr} !== want) begin
          n_err++;
          $display("FAIL b2b_%0d: got v=%b %0d/%0d/%0d want v=%b %0d/%0d/%0d", k - 2,
                   o_valid, o_y, o_cb, o_cr, want[24], want[23:16], want[15:8], want[7:0]);
        end
      end
    end
    tick();
  endtask

  task automatic test_full_clamp();
    set_mode(2'd2);
    drive(1'b1, 1'b0, 1'b0, 8'd255, 8'd0, 8'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick(); tick();
    n_cmp++;
    if ({o_valid, o_y, o_cb, o_cr} !== {1'b1, 8'd76, 8'd85, 8'd255}) begin
      n_err++;
      $display("FAIL full_red_clamp: got v=%b %0d/%0d/%0d want 1 76/85/255", o_valid, o_y, o_cb, o_cr);
    end
    tick();
  endtask

  task automatic test_bypass();
    set_mode(2'd3);
    drive(1'b1, 1'b0, 1'b0, 8'd10, 8'd20, 8'd30);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'd200, 8'd100, 8'd50);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    n_cmp++;
    if ({o_valid, o_y, o_cb, o_cr} !== {1'b1, 8'd20, 8'd30, 8'd10}) begin
      n_err++;
      $display("FAIL bypass: got v=%b %0d/%0d/%0d want 1 20/30/10", o_valid, o_y, o_cb, o_cr);
    end
    tick();
    n_cmp++;
    if ({o_valid, o_y, o_cb, o_cr} !== {1'b0, 8'd100, 8'd50, 8'd200}) begin
      n_err++;
      $display("FAIL bypass_invalid_tracks: got v=%b %0d/%0d/%0d want 0 100/50/200", o_valid, o_y, o_cb, o_cr);
    end
    tick();
  endtask
`else
  task automatic test_422();
    set_mode(2'd0);
    drive(1'b0, 1'b1, 1'b0, '0, '0, '0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 8'd255, 8'd0, 8'd0);
    tick(); tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    n_cmp++;
    if (o_hsync !== 1'b1) begin
      n_err++;
      $display("FAIL c422_hsync: got %b want 1", o_hsync);
    end
    tick();
    n_cmp++;
    if ({o_valid, o_cb, o_cr} !== {1'b1, 8'd90, 8'd0}) begin
      n_err++;
      $display("FAIL c422_phase0: got v=%b cb=%0d cr=%0d want 1 90 0", o_valid, o_cb, o_cr);
    end
    tick();
    n_cmp++;
    if ({o_valid, o_cb, o_cr} !== {1'b1, 8'd240, 8'd0}) begin
      n_err++;
      $display("FAIL c422_phase1: got v=%b cb=%0d cr=%0d want 1 240 0", o_valid, o_cb, o_cr);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
`ifndef FM_YCBCR_422_EN
    test_latency();
    test_back_to_back();
`endif
    test_flags();
`ifndef FM_YCBCR_422_EN
    test_full_clamp();
`endif
    test_mode_switch();
`ifndef FM_YCBCR_422_EN
    test_bypass();
`else
    test_422();
`endif
    test_reset_midstream();
    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
